// File: rtl/cp0_unit.sv
// Coprocessor-0 for the M stage: SR/Cause/EPC/PRId, mtc0/mfc0/eret, exception and interrupt entry.
// Latency: req, cp0_rdata and epc_out are combinational; register updates land on the next clk edge.
// Backpressure: none. req flushes the pipeline in the same cycle and suppresses that cycle's mtc0/eret.
module cp0_unit #(
  parameter logic [31:0] EXC_HANDLER_ADDR = 32'h0000_4180,
  parameter logic [31:0] PRID             = 32'h2023_0007
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic [4:0]  cp0_addr,
  input  logic [31:0] cp0_wdata,
  output logic [31:0] cp0_rdata,
  input  logic [31:0] vpc,
  input  logic        bd_in,
  input  logic [4:0]  exc_code_in,
  input  logic        eret,
  input  logic [5:0]  hw_int,
  output logic        req,
  output logic [31:0] epc_out,
  output logic [31:0] handler_pc
);

  localparam logic [4:0] ADDR_SR    = 5'd12;
  localparam logic [4:0] ADDR_CAUSE = 5'd13;
  localparam logic [4:0] ADDR_EPC   = 5'd14;
  localparam logic [4:0] ADDR_PRID  = 5'd15;

  logic [5:0]  sr_im_q,     sr_im_d;
  logic        sr_exl_q,    sr_exl_d;
  logic        sr_ie_q,     sr_ie_d;
  logic        cause_bd_q,  cause_bd_d;
  logic [5:0]  cause_ip_q,  cause_ip_d;
  logic [4:0]  cause_exc_q, cause_exc_d;
  logic [31:0] epc_q,       epc_d;

  logic        int_req;
  logic        exc_req;
  logic [31:0] sr_val;
  logic [31:0] cause_val;
  logic        wr_sr;
  logic        wr_epc;

  assign sr_val     = {16'd0, sr_im_q, 8'd0, sr_exl_q, sr_ie_q};
  assign cause_val  = {cause_bd_q, 15'd0, cause_ip_q, 3'd0, cause_exc_q, 2'd0};
  assign handler_pc = EXC_HANDLER_ADDR;

  // Entry decision: interrupts beat synchronous exceptions; EXL masks both; reset masks everything.
  always_comb begin
    int_req = (|(hw_int & sr_im_q)) & sr_ie_q & ~sr_exl_q;
    exc_req = (exc_code_in != 5'd0) & ~sr_exl_q;
    req     = (int_req | exc_req) & ~reset;
    wr_sr   = en & (cp0_addr == ADDR_SR)  & ~req;
    wr_epc  = en & (cp0_addr == ADDR_EPC) & ~req;
  end

  // mfc0 read port returns the pre-edge value; epc_out forwards an in-flight mtc0 EPC for eret.
  always_comb begin
    cp0_rdata = 32'd0;
    case (cp0_addr)
      ADDR_SR:    cp0_rdata = sr_val;
      ADDR_CAUSE: cp0_rdata = cause_val;
      ADDR_EPC:   cp0_rdata = epc_q;
      ADDR_PRID:  cp0_rdata = PRID;
      default:    cp0_rdata = 32'd0;
    endcase
    epc_out = wr_epc ? cp0_wdata : epc_q;
  end

  // Next-state: exception entry wins over the flushed instruction's own mtc0/eret.
  always_comb begin
    sr_im_d     = sr_im_q;
    sr_exl_d    = sr_exl_q;
    sr_ie_d     = sr_ie_q;
    cause_bd_d  = cause_bd_q;
    cause_ip_d  = hw_int;
    cause_exc_d = cause_exc_q;
    epc_d       = epc_q;
    if (req) begin
      sr_exl_d    = 1'b1;
      cause_bd_d  = bd_in;
      cause_exc_d = int_req ? 5'd0 : exc_code_in;
      epc_d       = bd_in ? (vpc - 32'd4) : vpc;
    end else begin
      if (wr_sr) begin
        sr_im_d  = cp0_wdata[15:10];
        sr_exl_d = cp0_wdata[1];
        sr_ie_d  = cp0_wdata[0];
      end
      if (wr_epc) begin
        epc_d = cp0_wdata;
      end
      // eret applied after the SR write so an mtc0 SR + eret pair still leaves EXL clear.
      if (eret) begin
        sr_exl_d = 1'b0;
      end
    end
  end

  // State registers with synchronous clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      sr_im_q     <= 6'd0;
      sr_exl_q    <= 1'b0;
      sr_ie_q     <= 1'b0;
      cause_bd_q  <= 1'b0;
      cause_ip_q  <= 6'd0;
      cause_exc_q <= 5'd0;
      epc_q       <= 32'd0;
    end else begin
      sr_im_q     <= sr_im_d;
      sr_exl_q    <= sr_exl_d;
      sr_ie_q     <= sr_ie_d;
      cause_bd_q  <= cause_bd_d;
      cause_ip_q  <= cause_ip_d;
      cause_exc_q <= cause_exc_d;
      epc_q       <= epc_d;
    end
  end

endmodule

// File: tb/tb_cp0_unit.sv
// Directed testbench for cp0_unit: hand-computed expectations for reset, entry, eret and write rules.
// Latency: inputs driven 1ns after posedge, outputs sampled before the next posedge.
// Backpressure: not applicable.
module tb_cp0_unit;

  localparam logic [31:0] PRID_V    = 32'h2023_0007;
  localparam logic [31:0] HANDLER_V = 32'h0000_4180;

  logic        clk;
  logic        reset;
  logic        en;
  logic [4:0]  cp0_addr;
  logic [31:0] cp0_wdata;
  logic [31:0] cp0_rdata;
  logic [31:0] vpc;
  logic        bd_in;
  logic [4:0]  exc_code_in;
  logic        eret;
  logic [5:0]  hw_int;
  logic        req;
  logic [31:0] epc_out;
  logic [31:0] handler_pc;

  int n_cmp = 0;
  int n_bad = 0;

  cp0_unit #(.EXC_HANDLER_ADDR(HANDLER_V), .PRID(PRID_V)) dut (
    .clk         (clk),
    .reset       (reset),
    .en          (en),
    .cp0_addr    (cp0_addr),
    .cp0_wdata   (cp0_wdata),
    .cp0_rdata   (cp0_rdata),
    .vpc         (vpc),
    .bd_in       (bd_in),
    .exc_code_in (exc_code_in),
    .eret        (eret),
    .hw_int      (hw_int),
    .req         (req),
    .epc_out     (epc_out),
    .handler_pc  (handler_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic rd(input string tag, input logic [4:0] a, input logic [31:0] exp);
    cp0_addr = a;
    #1;
    chk(tag, cp0_rdata, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    en          = 1'b0;
    eret        = 1'b0;
    exc_code_in = 5'd0;
    bd_in       = 1'b0;
    vpc         = 32'd0;
    cp0_wdata   = 32'd0;
    cp0_addr    = 5'd0;
  endtask

  initial begin
    reset  = 1'b1;
    hw_int = 6'd0;
    idle();
    step();
    // Reset held with a pending exception: req must stay low.
    exc_code_in = 5'd4;
    #1;
    chk("req_in_reset", {31'd0, req}, 32'd0);
    idle();
    step();
    reset = 1'b0;
    #1;
    rd("rst_sr", 5'd12, 32'd0);
    rd("rst_cause", 5'd13, 32'd0);
    rd("rst_epc", 5'd14, 32'd0);
    rd("rst_prid", 5'd15, PRID_V);
    rd("rst_unmapped", 5'd0, 32'd0);
    chk("rst_req", {31'd0, req}, 32'd0);
    chk("handler_pc", handler_pc, HANDLER_V);

    // Delay-slot exception at PC 0: EPC wraps to FFFF_FFFC.
    step();
    exc_code_in = 5'd1; vpc = 32'd0; bd_in = 1'b1;
    #1;
    chk("wrap_req", {31'd0, req}, 32'd1);
    step();
    idle();
    rd("wrap_epc", 5'd14, 32'hFFFF_FFFC);
    rd("wrap_sr", 5'd12, 32'h0000_0002);
    rd("wrap_cause", 5'd13, 32'h8000_0004);
    step();
    eret = 1'b1;
    step();
    idle();
    rd("eret1_sr", 5'd12, 32'd0);

    // Interrupt entry once SR enables IM[0] and IE.
    step();
    en = 1'b1; cp0_addr = 5'd12; cp0_wdata = 32'h0000_0401; hw_int = 6'b000001;
    #1;
    chk("int_pre_req", {31'd0, req}, 32'd0);
    step();
    idle();
    vpc = 32'h0000_3000;
    #1;
    chk("int_req", {31'd0, req}, 32'd1);
    step();
    idle();
    rd("int_cause", 5'd13, 32'h0000_0400);
    rd("int_sr", 5'd12, 32'h0000_0403);
    rd("int_epc", 5'd14, 32'h0000_3000);
    hw_int = 6'd0;
    eret   = 1'b1;
    step();
    idle();
    rd("eret2_sr", 5'd12, 32'h0000_0401);
    rd("eret2_cause", 5'd13, 32'd0);

    // Exception in a delay slot.
    step();
    exc_code_in = 5'd4; vpc = 32'h0000_3010; bd_in = 1'b1;
    #1;
    chk("exc_req", {31'd0, req}, 32'd1);
    step();
    idle();
    rd("exc_epc", 5'd14, 32'h0000_300C);
    rd("exc_cause", 5'd13, 32'h8000_0010);

    // EXL masks both exception and enabled interrupt; only IP tracks hw_int.
    step();
    exc_code_in = 5'd12; hw_int = 6'b000001; vpc = 32'h0000_3020;
    #1;
    chk("exl_req", {31'd0, req}, 32'd0);
    step();
    idle();
    hw_int = 6'd0;
    rd("exl_epc", 5'd14, 32'h0000_300C);
    rd("exl_sr", 5'd12, 32'h0000_0403);
    rd("exl_cause", 5'd13, 32'h8000_0410);

    // mtc0 EPC + eret in the same cycle: forwarded target, EXL cleared.
    step();
    en = 1'b1; cp0_addr = 5'd14; cp0_wdata = 32'h0000_3400; eret = 1'b1;
    #1;
    chk("fwd_epc_out", epc_out, 32'h0000_3400);
    chk("fwd_req", {31'd0, req}, 32'd0);
    step();
    idle();
    rd("fwd_sr", 5'd12, 32'h0000_0401);
    rd("fwd_epc", 5'd14, 32'h0000_3400);
    chk("fwd_epc_out_after", epc_out, 32'h0000_3400);

    // Cause is not writable.
    step();
    en = 1'b1; cp0_addr = 5'd13; cp0_wdata = 32'hFFFF_FFFF;
    step();
    idle();
    rd("cause_ro", 5'd13, 32'h8000_0010);

    // mtc0 SR dropped when the same instruction takes an exception.
    step();
    en = 1'b1; cp0_addr = 5'd12; cp0_wdata = 32'd0;
    exc_code_in = 5'd8; vpc = 32'h0000_5000;
    #1;
    chk("drop_req", {31'd0, req}, 32'd1);
    step();
    idle();
    rd("drop_sr", 5'd12, 32'h0000_0403);
    rd("drop_epc", 5'd14, 32'h0000_5000);
    rd("drop_cause", 5'd13, 32'h0000_0020);

    // SR write is masked to IM/EXL/IE.
    step();
    eret = 1'b1;
    step();
    idle();
    en = 1'b1; cp0_addr = 5'd12; cp0_wdata = 32'hFFFF_FFFF;
    step();
    idle();
    rd("sr_mask", 5'd12, 32'h0000_FC03);

    // Reset clears everything.
    reset = 1'b1;
    step();
    rd("rst2_sr", 5'd12, 32'd0);
    rd("rst2_epc", 5'd14, 32'd0);
    rd("rst2_cause", 5'd13, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
